// File: rtl/sdram_init_aref_ctrl.sv
// rtl/sdram_init_aref_ctrl.sv - SDR SDRAM power-up init sequencer plus periodic auto-refresh engine
module sdram_init_aref_ctrl #(
  parameter int          T_POWER     = 20000,
  parameter int          T_RP        = 2,
  parameter int          T_RFC       = 7,
  parameter int          T_MRD       = 3,
  parameter int          INIT_AR_NUM = 8,
  parameter int          AREF_NUM    = 2,
  parameter int          AREF_PERIOD = 750,
  parameter logic [12:0] MODE_VALUE  = 13'b000_0_00_011_0_111
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        aref_en,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic        init_end,
  output logic        aref_req,
  output logic        aref_end
);

  localparam int CNT_W  = $clog2(T_POWER + 1);
  localparam int IAR_W  = $clog2(INIT_AR_NUM + 1);
  localparam int RAR_W  = $clog2(AREF_NUM + 1);
  localparam int RCNT_W = $clog2(((T_RFC > T_RP) ? T_RFC : T_RP) + 1);
  localparam int TMR_W  = $clog2(AREF_PERIOD);

  localparam logic [CNT_W-1:0]  POWER_LAST = CNT_W'(T_POWER);
  localparam logic [CNT_W-1:0]  IRP_LAST   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0]  IRFC_LAST  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0]  IMRD_LAST  = CNT_W'(T_MRD - 1);
  localparam logic [IAR_W-1:0]  IAR_LAST   = IAR_W'(INIT_AR_NUM);
  localparam logic [RCNT_W-1:0] RRP_LAST   = RCNT_W'(T_RP - 1);
  localparam logic [RCNT_W-1:0] RRFC_LAST  = RCNT_W'(T_RFC - 1);
  localparam logic [RAR_W-1:0]  RAR_LAST   = RAR_W'(AREF_NUM);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(AREF_PERIOD - 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam logic [2:0] I_WAIT = 3'd0;
  localparam logic [2:0] I_PRE  = 3'd1;
  localparam logic [2:0] I_TRP  = 3'd2;
  localparam logic [2:0] I_AR   = 3'd3;
  localparam logic [2:0] I_TRF  = 3'd4;
  localparam logic [2:0] I_MRS  = 3'd5;
  localparam logic [2:0] I_TMRD = 3'd6;
  localparam logic [2:0] I_END  = 3'd7;

  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_PRE  = 3'd1;
  localparam logic [2:0] R_TRP  = 3'd2;
  localparam logic [2:0] R_AR   = 3'd3;
  localparam logic [2:0] R_TRF  = 3'd4;
  localparam logic [2:0] R_END  = 3'd5;

  logic [2:0]        i_state_q, i_state_d;
  logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
  logic [IAR_W-1:0]  i_ar_q, i_ar_d;
  logic [2:0]        r_state_q, r_state_d;
  logic [RCNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [RAR_W-1:0]  r_ar_q, r_ar_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              init_end_q, init_end_d;
  logic              aref_req_q, aref_req_d;
  logic              aref_end_q, aref_end_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [1:0]        ba_q, ba_d;
  logic [12:0]       addr_q, addr_d;
  logic              tmr_wrap;
  logic              r_leave;

  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_ar_d    = i_ar_q;
    case (i_state_q)
      I_WAIT: begin
        if (i_cnt_q == POWER_LAST) begin
          i_state_d = I_PRE;
          i_cnt_d   = '0;
        end else begin
          i_cnt_d = i_cnt_q + 1'b1;
        end
      end
      I_PRE: i_state_d = I_TRP;
      I_TRP: begin
        if (i_cnt_q == IRP_LAST) begin
          i_state_d = I_AR;
          i_cnt_d   = '0;
        end else begin
          i_cnt_d = i_cnt_q + 1'b1;
        end
      end
      I_AR: begin
        i_state_d = I_TRF;
        i_ar_d    = i_ar_q + 1'b1;
      end
      I_TRF: begin
        if (i_cnt_q == IRFC_LAST) begin
          i_state_d = (i_ar_q == IAR_LAST) ? I_MRS : I_AR;
          i_cnt_d   = '0;
        end else begin
          i_cnt_d = i_cnt_q + 1'b1;
        end
      end
      I_MRS: i_state_d = I_TMRD;
      I_TMRD: begin
        if (i_cnt_q == IMRD_LAST) begin
          i_state_d = I_END;
          i_cnt_d   = '0;
        end else begin
          i_cnt_d = i_cnt_q + 1'b1;
        end
      end
      default: i_state_d = I_END;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_ar_d    = r_ar_q;
    case (r_state_q)
      R_IDLE: begin
        if (init_end_q && aref_en) begin
          r_state_d = R_PRE;
          r_cnt_d   = '0;
          r_ar_d    = '0;
        end
      end
      R_PRE: r_state_d = R_TRP;
      R_TRP: begin
        if (r_cnt_q == RRP_LAST) begin
          r_state_d = R_AR;
          r_cnt_d   = '0;
        end else begin
          r_cnt_d = r_cnt_q + 1'b1;
        end
      end
      R_AR: begin
        r_state_d = R_TRF;
        r_ar_d    = r_ar_q + 1'b1;
      end
      R_TRF: begin
        if (r_cnt_q == RRFC_LAST) begin
          r_state_d = (r_ar_q == RAR_LAST) ? R_END : R_AR;
          r_cnt_d   = '0;
        end else begin
          r_cnt_d = r_cnt_q + 1'b1;
        end
      end
      R_END: begin
        r_state_d = R_IDLE;
        r_ar_d    = '0;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // A timer wrap coinciding with a burst start wins: that new request stays pending.
  always_comb begin
    tmr_d    = tmr_q;
    tmr_wrap = 1'b0;
    if (init_end_q) begin
      if (tmr_q == TMR_LAST) begin
        tmr_d    = '0;
        tmr_wrap = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
    r_leave    = (r_state_q == R_IDLE) && (r_state_d != R_IDLE);
    aref_req_d = tmr_wrap ? 1'b1 : (r_leave ? 1'b0 : aref_req_q);
    init_end_d = (i_state_d == I_END);
    aref_end_d = (r_state_d == R_END);
  end

  // Bus is decoded from next state so the command appears in the cycle its state is occupied.
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = 2'b11;
    addr_d = 13'h1FFF;
    if (init_end_d) begin
      case (r_state_d)
        R_PRE:   cmd_d = CMD_PRE;
        R_AR:    cmd_d = CMD_AREF;
        default: cmd_d = CMD_NOP;
      endcase
    end else begin
      case (i_state_d)
        I_PRE: cmd_d = CMD_PRE;
        I_AR:  cmd_d = CMD_AREF;
        I_MRS: begin
          cmd_d  = CMD_MRS;
          ba_d   = 2'b00;
          addr_d = MODE_VALUE;
        end
        default: cmd_d = CMD_NOP;
      endcase
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      i_state_q  <= I_WAIT;
      i_cnt_q    <= '0;
      i_ar_q     <= '0;
      r_state_q  <= R_IDLE;
      r_cnt_q    <= '0;
      r_ar_q     <= '0;
      tmr_q      <= '0;
      init_end_q <= 1'b0;
      aref_req_q <= 1'b0;
      aref_end_q <= 1'b0;
      cmd_q      <= CMD_NOP;
      ba_q       <= 2'b11;
      addr_q     <= 13'h1FFF;
    end else begin
      i_state_q  <= i_state_d;
      i_cnt_q    <= i_cnt_d;
      i_ar_q     <= i_ar_d;
      r_state_q  <= r_state_d;
      r_cnt_q    <= r_cnt_d;
      r_ar_q     <= r_ar_d;
      tmr_q      <= tmr_d;
      init_end_q <= init_end_d;
      aref_req_q <= aref_req_d;
      aref_end_q <= aref_end_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
    end
  end

  assign sdram_cmd  = cmd_q;
  assign sdram_ba   = ba_q;
  assign sdram_addr = addr_q;
  assign init_end   = init_end_q;
  assign aref_req   = aref_req_q;
  assign aref_end   = aref_end_q;

endmodule

// File: tb/tb_sdram_init_aref_ctrl.sv
// tb/tb_sdram_init_aref_ctrl.sv - randomized bench for sdram_init_aref_ctrl against a command-schedule model
module tb_sdram_init_aref_ctrl;

  localparam int T_POWER     = 20000;
  localparam int T_RP        = 2;
  localparam int T_RFC       = 7;
  localparam int T_MRD       = 3;
  localparam int INIT_AR_NUM = 8;
  localparam int AREF_NUM    = 2;
  localparam int AREF_PERIOD = 750;

  localparam logic [19:0] W_NOP = {1'b0, 4'b0111, 2'b11, 13'h1FFF};
  localparam logic [19:0] W_PRE = {1'b0, 4'b0010, 2'b11, 13'h1FFF};
  localparam logic [19:0] W_AR  = {1'b0, 4'b0001, 2'b11, 13'h1FFF};
  localparam logic [19:0] W_MRS = {1'b0, 4'b0000, 2'b00, 13'h0037};
  localparam logic [19:0] W_END = {1'b1, 4'b0111, 2'b11, 13'h1FFF};

  logic        clk_100m = 1'b0;
  logic        rst_n;
  logic        aref_en;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic        init_end;
  logic        aref_req;
  logic        aref_end;

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  sdram_init_aref_ctrl dut (
    .clk_100m   (clk_100m),
    .rst_n      (rst_n),
    .aref_en    (aref_en),
    .sdram_cmd  (sdram_cmd),
    .sdram_ba   (sdram_ba),
    .sdram_addr (sdram_addr),
    .init_end   (init_end),
    .aref_req   (aref_req),
    .aref_end   (aref_end)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bus words, one per cycle, as {aref_end, cmd, ba, addr}.
  logic [19:0] exp_q[$];
  logic [19:0] m_cur = W_NOP;
  bit          m_fresh = 1'b1;
  bit          m_done = 1'b0;
  bit          m_req = 1'b0;
  int          m_since = 0;
  int          edge_n = 0;
  bit          seen_pre, seen_ie, seen_req;
  bit          have_last;
  logic [3:0]  last_cmd;
  int          nop_run;

  function automatic void push_init();
    for (int i = 0; i < T_POWER; i++) exp_q.push_back(W_NOP);
    exp_q.push_back(W_PRE);
    for (int i = 0; i < T_RP; i++) exp_q.push_back(W_NOP);
    for (int a = 0; a < INIT_AR_NUM; a++) begin
      exp_q.push_back(W_AR);
      for (int i = 0; i < T_RFC; i++) exp_q.push_back(W_NOP);
    end
    exp_q.push_back(W_MRS);
    for (int i = 0; i < T_MRD; i++) exp_q.push_back(W_NOP);
  endfunction

  // The trailing NOP is the cycle after aref_end in which aref_en is not looked at.
  function automatic void push_burst();
    exp_q.push_back(W_PRE);
    for (int i = 0; i < T_RP; i++) exp_q.push_back(W_NOP);
    for (int a = 0; a < AREF_NUM; a++) begin
      exp_q.push_back(W_AR);
      for (int i = 0; i < T_RFC; i++) exp_q.push_back(W_NOP);
    end
    exp_q.push_back(W_END);
    exp_q.push_back(W_NOP);
  endfunction

  always @(posedge clk_100m) begin
    bit en_s;
    bit leave;
    int need;
    en_s  = aref_en;
    leave = 1'b0;
    if (!rst_n) begin
      m_fresh   = 1'b1;
      m_done    = 1'b0;
      m_req     = 1'b0;
      m_since   = 0;
      m_cur     = W_NOP;
      edge_n    = 0;
      seen_pre  = 1'b0;
      seen_ie   = 1'b0;
      seen_req  = 1'b0;
      have_last = 1'b0;
      nop_run   = 0;
      exp_q.delete();
    end else begin
      edge_n++;
      if (m_fresh) begin
        m_fresh = 1'b0;
        push_init();
      end
      if (!m_done) begin
        if (exp_q.size() > 0) m_cur = exp_q.pop_front();
        else begin
          m_done = 1'b1;
          m_cur  = W_NOP;
        end
      end else begin
        m_since++;
        if (exp_q.size() > 0) m_cur = exp_q.pop_front();
        else if (en_s) begin
          push_burst();
          m_cur = exp_q.pop_front();
          leave = 1'b1;
        end else m_cur = W_NOP;
        if (m_since % AREF_PERIOD == 0) m_req = 1'b1;
        else if (leave) m_req = 1'b0;
      end
    end
    #1;
    chk("bus", {12'd0, aref_end, sdram_cmd, sdram_ba, sdram_addr}, {12'd0, m_cur});
    chk("init_end", {31'd0, init_end}, {31'd0, m_done});
    chk("aref_req", {31'd0, aref_req}, {31'd0, m_req});
    if (rst_n) begin
      if (!seen_pre && sdram_cmd == 4'b0010) begin
        seen_pre = 1'b1;
        chk("first_pre_cycle", edge_n, 20001);
      end
      if (!seen_ie && init_end) begin
        seen_ie = 1'b1;
        chk("init_end_cycle", edge_n, 20072);
      end
      if (!seen_req && aref_req) begin
        seen_req = 1'b1;
        if (mode == 0) chk("first_req_cycle", edge_n, 20822);
      end
      if (sdram_cmd == 4'b0000) chk("mrs_word", {17'd0, sdram_ba, sdram_addr}, {17'd0, 2'b00, 13'h0037});
      if (sdram_cmd == 4'b0111) nop_run++;
      else begin
        if (have_last) begin
          need = (last_cmd == 4'b0010) ? T_RP : (last_cmd == 4'b0001) ? T_RFC : T_MRD;
          chk("cmd_spacing", {31'd0, nop_run >= need}, 32'd1);
        end
        have_last = 1'b1;
        last_cmd  = sdram_cmd;
        nop_run   = 0;
      end
    end
  end

  // Arbiter-like driver; mode 1 grants on init_end&aref_req and drops at aref_end.
  always @(negedge clk_100m) begin
    case (mode)
      1: begin
        if (aref_end) aref_en = 1'b0;
        else if (init_end && aref_req) aref_en = 1'b1;
      end
      2: aref_en = ($urandom_range(0, 3) == 0);
      3: aref_en = 1'b1;
      default: aref_en = 1'b0;
    endcase
  end

  initial begin
    bit got;
    rst_n   = 1'b0;
    aref_en = 1'b0;
    repeat (3) @(negedge clk_100m);
    rst_n = 1'b1;
    repeat (20030) @(negedge clk_100m);
    rst_n = 1'b0;
    #1;
    chk("abort_bus", {12'd0, aref_end, sdram_cmd, sdram_ba, sdram_addr}, {12'd0, W_NOP});
    chk("abort_init_end", {31'd0, init_end}, 32'd0);
    repeat (3) @(negedge clk_100m);
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 25000 && !got; i++) begin
      @(negedge clk_100m);
      got = init_end;
    end
    chk("init_end_timeout", {31'd0, got}, 32'd1);
    repeat (800) @(negedge clk_100m);
    chk("req_held", {31'd0, aref_req}, 32'd1);
    chk("bus_idle_held", {28'd0, sdram_cmd}, 32'h7);
    mode = 1;
    repeat (AREF_PERIOD * 5) @(negedge clk_100m);
    mode = 2;
    repeat (3000) @(negedge clk_100m);
    mode = 3;
    repeat (500) @(negedge clk_100m);
    mode = 1;
    repeat (1500) @(negedge clk_100m);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
